// File: rtl/hpdmc_ddr_rdcapture.sv
// hpdmc_ddr_rdcapture: captures DDR read bursts on both clock edges and assembles 32-bit words,
// tracking accepted reads through a CAS-deep pipeline and flagging reads whose windows would overlap.
module hpdmc_ddr_rdcapture #(
    parameter int CAS_CYCLES  = 3,
    parameter int BURST_BEATS = 4
) (
    input  logic        i_sys_clk,
    input  logic        i_sys_rst_n,
    input  logic        i_rd_start,
    input  logic [15:0] i_dq_in,
    input  logic        i_err_clr,
    output logic [31:0] o_rd_data,
    output logic        o_rd_valid,
    output logic        o_rd_last,
    output logic        o_rd_busy,
    output logic        o_err_overlap
);
    localparam int WORDS = BURST_BEATS / 2;
    localparam int GW = $clog2(WORDS + 1);
    localparam logic [GW-1:0] L_WORDS = GW'(WORDS);
    localparam logic [GW-1:0] L_WORDS_M1 = GW'(WORDS - 1);
    localparam logic [GW-1:0] L_ONE = GW'(1);

    logic [GW-1:0]         r_gap;
    logic [GW-1:0]         r_cnt;
    logic [CAS_CYCLES-1:0] r_pend;
    logic [15:0]           r_rise;
    logic [15:0]           r_fall;
    logic                  r_cap_v;
    logic                  r_cap_last;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_start;
    logic                  w_cap;
    logic                  w_last;

    // r_gap saturates at WORDS: cycles since the last accepted read, so spacing alone decides overlap
    assign w_accept = i_rd_start && (r_gap >= L_WORDS);
    assign w_reject = i_rd_start && !w_accept;
    assign w_start  = r_pend[CAS_CYCLES-1];
    assign w_cap    = w_start || (r_cnt != '0);
    assign w_last   = w_start ? (WORDS == 1) : (r_cnt == L_ONE);

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_gap         <= L_WORDS;
            r_cnt         <= '0;
            r_pend        <= '0;
            r_rise        <= '0;
            r_cap_v       <= 1'b0;
            r_cap_last    <= 1'b0;
            o_rd_data     <= '0;
            o_rd_valid    <= 1'b0;
            o_rd_last     <= 1'b0;
            o_rd_busy     <= 1'b0;
            o_err_overlap <= 1'b0;
        end else begin
            r_gap         <= w_accept ? L_ONE : (r_gap < L_WORDS ? r_gap + L_ONE : r_gap);
            r_pend        <= {r_pend[CAS_CYCLES-2:0], w_accept};
            r_cnt         <= w_start ? L_WORDS_M1 : (r_cnt != '0 ? r_cnt - L_ONE : r_cnt);
            r_rise        <= w_cap ? i_dq_in : r_rise;
            r_cap_v       <= w_cap;
            r_cap_last    <= w_cap && w_last;
            o_rd_data     <= r_cap_v ? {r_rise, r_fall} : o_rd_data;
            o_rd_valid    <= r_cap_v;
            o_rd_last     <= r_cap_v && r_cap_last;
            o_rd_busy     <= w_accept || (|r_pend) || w_cap || r_cap_v;
            o_err_overlap <= w_reject ? 1'b1 : (i_err_clr ? 1'b0 : o_err_overlap);
        end
    end

    // falling half is picked up by the next rising edge: a half-cycle path, no added latency
    always_ff @(negedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) r_fall <= '0;
        else if (r_cap_v) r_fall <= i_dq_in;
    end
endmodule

// File: tb/tb_hpdmc_ddr_rdcapture.sv
// tb_hpdmc_ddr_rdcapture: scoreboard bench over five CAS/burst configurations; a per-config
// reference model predicts words, timing, busy and overlap errors from the read-acceptance rules.
module tb_hpdmc_ddr_rdcapture;
    localparam int NCFG = 5;

    function automatic int cas_of(int i);
        return i == 0 ? 3 : (i < 3 ? 2 : 7);
    endfunction

    function automatic int bb_of(int i);
        return i == 0 ? 4 : ((i == 1 || i == 3) ? 2 : 8);
    endfunction

    typedef struct {
        logic [31:0] d;
        logic        l;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    function automatic void chk(int g, string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s: got %h expected %h at %0t", g, name, act, exp, $time);
        end
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int CAS = cas_of(g);
        localparam int W = bb_of(g) / 2;

        logic        rst_n = 1'b0;
        logic        rd_start = 1'b0;
        logic        err_clr = 1'b0;
        logic [15:0] dq = '0;
        logic [31:0] rd_data;
        logic        rd_valid;
        logic        rd_last;
        logic        rd_busy;
        logic        err;
        logic [15:0] rise_a [4096];
        logic [15:0] fall_a [4096];
        exp_t        q[$];
        int          acc[$];
        int          cyc = 0;
        int          last_acc = -1000;
        bit          err_m = 1'b0;
        bit          mon_en = 1'b0;
        bit          done = 1'b0;
        logic [31:0] last_d = '0;
        exp_t        e;
        bit          ev;
        bit          eb;

        hpdmc_ddr_rdcapture #(.CAS_CYCLES(CAS), .BURST_BEATS(bb_of(g))) u_dut (
            .i_sys_clk    (clk),
            .i_sys_rst_n  (rst_n),
            .i_rd_start   (rd_start),
            .i_dq_in      (dq),
            .i_err_clr    (err_clr),
            .o_rd_data    (rd_data),
            .o_rd_valid   (rd_valid),
            .o_rd_last    (rd_last),
            .o_rd_busy    (rd_busy),
            .o_err_overlap(err)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Drive one rising edge (start/clr + rise data) and its falling half; update the model.
        task automatic step(input bit s, input bit clr);
            int  n;
            bit  rej;
            n = cyc + 1;
            rd_start = s;
            err_clr = clr;
            dq = rise_a[n];
            rej = s && (n - last_acc < W);
            if (s && !rej) begin
                last_acc = n;
                acc.push_back(n);
                for (int k = 0; k < W; k++)
                    q.push_back('{{rise_a[n+CAS+k], fall_a[n+CAS+k]}, (k == W - 1), n + CAS + k + 1});
            end
            err_m = rej ? 1'b1 : (clr ? 1'b0 : err_m);
            @(posedge clk);
            #1;
            dq = fall_a[n];
            @(negedge clk);
            #1;
        endtask

        task automatic check_zero(input string tag);
            chk(g, {tag, "_rd_data"}, rd_data, 32'h0);
            chk(g, {tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
            chk(g, {tag, "_rd_last"}, 32'(rd_last), 32'h0);
            chk(g, {tag, "_rd_busy"}, 32'(rd_busy), 32'h0);
            chk(g, {tag, "_err"}, 32'(err), 32'h0);
        endtask

        always @(negedge clk) begin
            if (mon_en) begin
                ev = q.size() != 0 && q[0].due <= cyc;
                chk(g, "rd_valid", 32'(rd_valid), 32'(ev));
                if (ev) begin
                    e = q.pop_front();
                    chk(g, "rd_data", rd_data, e.d);
                    chk(g, "rd_last", 32'(rd_last), 32'(e.l));
                    last_d = e.d;
                end else begin
                    chk(g, "rd_last_idle", 32'(rd_last), 32'h0);
                    chk(g, "rd_data_hold", rd_data, last_d);
                end
                while (acc.size() != 0 && acc[0] + CAS + W < cyc) void'(acc.pop_front());
                eb = acc.size() != 0 && acc[0] <= cyc;
                chk(g, "rd_busy", 32'(rd_busy), 32'(eb));
                chk(g, "err_overlap", 32'(err), 32'(err_m));
            end
        end

        initial begin
            for (int i = 0; i < 4096; i++) begin
                rise_a[i] = 16'($urandom);
                fall_a[i] = 16'($urandom);
            end
            repeat (3) @(posedge clk);
            @(negedge clk);
            #1;
            check_zero("reset");
            rst_n = 1'b1;
            #1;
            mon_en = 1'b1;
            // single read with incrementing data (1111/2222, 3333/4444, ...)
            for (int k = 0; k < W; k++) begin
                rise_a[cyc + 1 + CAS + k] = 16'(16'h1111 * (2 * k + 1));
                fall_a[cyc + 1 + CAS + k] = 16'(16'h1111 * (2 * k + 2));
            end
            step(1, 0);
            repeat (CAS + W + 2) step(0, 0);
            // back-to-back reads exactly W apart
            step(1, 0);
            repeat (W - 1) step(0, 0);
            step(1, 0);
            repeat (CAS + W + 2) step(0, 0);
            // overlapping start, then clear; then clear coinciding with a rejection
            step(1, 0);
            step(1, 0);
            repeat (CAS + W + 2) step(0, 0);
            step(0, 1);
            step(0, 0);
            step(1, 0);
            step(1, 1);
            step(0, 0);
            step(0, 1);
            repeat (CAS + W + 2) step(0, 0);
            repeat (400) step($urandom_range(2) == 0, $urandom_range(15) == 0);
            repeat (CAS + W + 2) step(0, 0);
            // reset while a burst is being delivered
            step(1, 0);
            repeat (CAS + 1) step(0, 0);
            mon_en = 1'b0;
            rst_n = 1'b0;
            #1;
            check_zero("midreset");
            q.delete();
            acc.delete();
            last_acc = -1000;
            err_m = 1'b0;
            last_d = '0;
            #1;
            rst_n = 1'b1;
            #1;
            mon_en = 1'b1;
            repeat (CAS + W + 2) step(0, 0);
            step(1, 0);
            repeat (CAS + W + 2) step(0, 0);
            chk(g, "queue_drained", 32'(q.size()), 32'h0);
            done = 1'b1;
        end
    end

    wire [NCFG-1:0] all_done = {g_cfg[4].done, g_cfg[3].done, g_cfg[2].done, g_cfg[1].done, g_cfg[0].done};

    initial begin
        for (int i = 0; i < 20000 && all_done != '1; i++) @(posedge clk);
        if (all_done != '1) begin
            n_fail++;
            $display("FAIL timeout: done flags %b expected %b", all_done, {NCFG{1'b1}});
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
